// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mult_pkg;

    // FSM encoding; 2'b11 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFin  = 2'b10
    } state_e;

    localparam int unsigned DefaultWidth = 8;

    // Counter must hold values up to WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_adder.sv
// WIDTH-bit ripple-carry adder built from full-adder bit slices.
module seq_mult_adder
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[WIDTH];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: one shift-add step per RUN cycle, WIDTH steps per product.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mc_q, mc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry;
    logic [WIDTH-1:0]     step_hi;
    logic [WIDTH-1:0]     step_lo;
    logic                 last;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = lo_q[0] ? mc_q : '0;

    seq_mult_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a  (hi_q),
        .b  (addend),
        .s  (sum),
        .co (carry)
    );

    // Carry enters at the top so no product bit is lost by the shift.
    assign step_hi = {carry, sum[WIDTH-1:1]};
    assign step_lo = {sum[0], lo_q[WIDTH-1:1]};
    assign last    = (cnt_q == CntW'(WIDTH - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mc_d    = a;
                    lo_d    = b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    p_d     = {step_hi, step_lo};
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            mc_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Status decoded purely from the state register.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StFin);
        p    = p_q;
    end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RSTB  input  1  reset; asynchronous, active-low.
REQ-004 START  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 A  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge.
REQ-006 B  input  WIDTH  multiplier, unsigned; sampled on the accepting edge.
REQ-007 BUSY  output  1  high while a multiply is in progress (RUN state).
REQ-008 DONE  output  1  single-cycle pulse; P is valid from this cycle onward.
REQ-009 P  output  2*WIDTH  unsigned product; holds until the next completion.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-011 IDLE with START=1 at an edge SHALL:
- latch A into the multiplicand register (MC);
- latch B into the low half of the accumulator;
- clear the high half of the accumulator and the carry bit;
- clear the iteration counter;
- move to RUN.
REQ-012 IDLE with START=0 SHALL hold the state; inputs A and B are ignored.
REQ-013 Each RUN cycle SHALL perform one shift-add step:
- if acc[0]=1, form {carry, hi} = hi + MC, otherwise form {carry, hi} = {0, hi};
- shift {carry, hi, lo} right by one bit into {hi, lo};
- increment the counter.
REQ-014 RUN SHALL last exactly WIDTH cycles, independent of operand values (no early exit on zero operands), then move to FIN.
REQ-015 On entry to FIN, P SHALL load {hi, lo}; DONE SHALL be 1 for that single cycle; FIN SHALL always move to IDLE on the next edge.
REQ-016 Latency: START sampled at edge k -> BUSY=1 for cycles k+1..k+WIDTH -> DONE=1 and P valid in cycle k+WIDTH+1.
REQ-017 START SHALL be ignored in RUN and FIN; such a request is not queued.
REQ-018 START held high continuously SHALL produce back-to-back operations with a period of WIDTH+2 cycles.
REQ-019 Arithmetic width rules:
- the adder is WIDTH bits wide with carry-out;
- the carry is retained for the shift, so no result bit is lost;
- P = A*B exactly for all operands, maximum (2^WIDTH-1)^2.
REQ-020 The counter SHALL be ceil(log2(WIDTH+1)) bits wide; the terminal compare is count==WIDTH-1 while in RUN.
REQ-021 BUSY and DONE SHALL be decoded from registered state only, with no combinational path from any input.
REQ-022 P SHALL update only on entry to FIN; it keeps its value through IDLE and RUN.

Reset
REQ-023 RSTB=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- BUSY=0, DONE=0;
- P, MC, accumulator, carry and counter to 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no DONE is produced for it.
REQ-025 After RSTB deasserts, the first START is accepted on the first rising edge that samples RSTB=1.

Structure
REQ-026 Shared package seq_mult_pkg SHALL hold:
- the state encoding (IDLE=2'b00, RUN=2'b01, FIN=2'b10);
- the WIDTH default;
- the counter-width constant function.
REQ-027 Unused state encoding 2'b11 SHALL recover to IDLE on the next edge.
REQ-028 One sub-module, seq_mult_adder: WIDTH-bit ripple-carry adder built as a chain of full-adder bit slices, with ports a, b, s, co.
REQ-029 The FSM, counter and shift register SHALL reside in seq_mult_ctrl; there SHALL be no other hierarchy.

Verification
REQ-030 WIDTH=8, A=13, B=11, one START pulse -> BUSY high for 8 cycles; DONE pulse 9 cycles after the START edge; P=143.
REQ-031 A=255, B=255 -> P=16'hFE01; also A=0, B=200 -> P=0 with the same 9-cycle latency.
REQ-032 START held high with A=3, B=5 -> DONE every 10 cycles; P=15 each time; BUSY low exactly 2 cycles per period.
REQ-033 START pulsed during RUN with different A and B -> ignored; the original product is delivered and no extra DONE occurs.
REQ-034 RSTB low at RUN cycle 4 -> BUSY, DONE and P are 0 immediately; no DONE follows; a new START after release gives the correct product.
REQ-035 Random A/B regression (at least 1000 operations, WIDTH=8 and WIDTH=16) -> P==A*B at every DONE, with one DONE per accepted START.
